// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract: streams NWORDS 32-bit slices through one shared
// prefix adder, LSW first, with the inter-word carry held in a register.
module prefix_adder (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        c_i,
  output logic [31:0] s_o,
  output logic        c_o
);
  // Kogge-Stone: carry-in is folded into bit 0 generate, so G[i] is the carry out of bit i.
  always_comb begin
    logic [31:0] g, p, pp, gn, pn;
    p    = a_i ^ b_i;
    g    = a_i & b_i;
    g[0] = g[0] | (p[0] & c_i);
    pp   = p;
    for (int d = 1; d < 32; d = d * 2) begin
      gn = g;
      pn = pp;
      for (int i = d; i < 32; i++) begin
        gn[i] = g[i] | (pp[i] & g[i-d]);
        pn[i] = pp[i] & pp[i-d];
      end
      g  = gn;
      pp = pn;
    end
    s_o = p ^ {g[30:0], c_i};
    c_o = g[31];
  end
endmodule

module wide_add_sequencer #(
  parameter  int NWORDS = 4,
  localparam int W      = 32 * NWORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic         cin,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf
);
  localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_q;
  logic [NWORDS-1:0][31:0]  a_q, b_q, res_q;
  logic [IDXW-1:0]          idx_q;
  logic                     carry_q, busy_q, done_q, cout_q, ovf_q;
  logic [31:0]              sum;
  logic                     sum_c;
  logic                     last;

  prefix_adder u_add (
    .a_i (a_q[idx_q]),
    .b_i (b_q[idx_q]),
    .c_i (carry_q),
    .s_o (sum),
    .c_o (sum_c)
  );

  assign last = (idx_q == IDXW'(NWORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= opa;
            b_q     <= sub ? ~opb : opb;
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q[idx_q] <= sum;
          carry_q      <= sum_c;
          if (last) begin
            // Overflow uses the effective B, so subtract needs no special case.
            cout_q  <= sum_c;
            ovf_q   <= (a_q[NWORDS-1][31] == b_q[NWORDS-1][31]) &&
                       (sum[31] != a_q[NWORDS-1][31]);
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: arithmetic model on W+1-bit integers plus a
// cycle-window timeline, checked every cycle, pinned by directed literals.
module tb_wide_add_sequencer;
  localparam int NW = 4;
  localparam int W  = 32 * NW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [W-1:0] opa = '0, opb = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  wide_add_sequencer #(.NWORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
    .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result),
    .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  int           cyc = 0;
  bit           active = 0;
  int           t0 = 0, done_at = 0, free_at = 0;
  logic [W-1:0] pend_res = '0, exp_res = '0;
  logic         pend_cout = 0, pend_ovf = 0, exp_cout = 0, exp_ovf = 0;
  bit           res_ok = 1;

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, input logic c);
    logic [W-1:0] be;
    logic [W:0]   full;
    logic         o;
    be   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + (s ? 1 : c);
    o    = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
    return {o, full[W], full[W-1:0]};
  endfunction

  always @(posedge clk) begin
    if (rst_n && start && cyc >= free_at) begin
      logic [W+1:0] m;
      m         = model(opa, opb, sub, cin);
      {pend_ovf, pend_cout, pend_res} = m;
      active    = 1;
      t0        = cyc;
      done_at   = cyc + NW + 1;
      free_at   = cyc + NW + 2;
      res_ok    = 0;
    end
    cyc++;
  end

  always @(negedge rst_n) begin
    active   = 0;
    free_at  = 0;
    exp_res  = '0;
    exp_cout = 0;
    exp_ovf  = 0;
    res_ok   = 1;
  end

  always @(negedge clk) begin
    logic eb, ed;
    if (active && cyc == done_at) begin
      exp_res  = pend_res;
      exp_cout = pend_cout;
      exp_ovf  = pend_ovf;
      res_ok   = 1;
    end
    eb = active && cyc > t0 && cyc <= done_at;
    ed = active && cyc == done_at;
    chk("busy", W'(busy), W'(eb));
    chk("done", W'(done), W'(ed));
    chk("cout", W'(cout), W'(exp_cout));
    chk("ovf",  W'(ovf),  W'(exp_ovf));
    if (res_ok) chk("result", result, exp_res);
  end

  // ---------------- directed ----------------
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c, input logic [W-1:0] er,
                        input logic ec, input logic eo, input bit glitch);
    int n;
    bit got;
    @(negedge clk); #1;
    opa = a; opb = b; sub = s; cin = c; start = 1;
    n = 0; got = 0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      if (done) got = 1;
      #1;
      if (n == 1) begin
        start = 0;
        opa = {$urandom, $urandom, $urandom, $urandom};
        opb = {$urandom, $urandom, $urandom, $urandom};
        sub = ~s;
      end
      if (glitch && n == 2) start = 1;
      if (glitch && n == 3) start = 0;
    end
    if (!got) chk({name, "_timeout"}, W'(0), W'(1));
    else begin
      chk({name, "_latency"}, W'(n), W'(NW + 1));
      chk({name, "_res"}, result, er);
      chk({name, "_cout"}, W'(cout), W'(ec));
      chk({name, "_ovf"}, W'(ovf), W'(eo));
      chk({name, "_model"}, {pend_res}, er);
      chk({name, "_model_flags"}, W'({pend_cout, pend_ovf}), W'({ec, eo}));
    end
  endtask

  logic [W-1:0] ONES, MSB, MAXP;

  initial begin
    int dc[3];
    int k, n, cnt;
    ONES = '1;
    MSB  = {1'b1, {(W-1){1'b0}}};
    MAXP = ~MSB;

    repeat (3) @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_result", result, '0);
    #1 rst_n = 1;
    repeat (2) @(negedge clk);

    run_op("add_ones", ONES, W'(1), 0, 0, '0, 1, 0, 0);
    run_op("xword", W'(128'hFFFFFFFF), W'(1), 0, 0, W'(128'h1_00000000), 0, 0, 0);
    run_op("cin", '0, '0, 0, 1, W'(1), 0, 0, 0);
    run_op("sub_neg", W'(5), W'(7), 1, 0, ONES - W'(1), 0, 0, 0);
    run_op("sub_pos", W'(7), W'(5), 1, 0, W'(2), 1, 0, 0);
    run_op("ovf_add", MAXP, W'(1), 0, 0, MSB, 0, 1, 0);
    run_op("ovf_sub", MSB, W'(1), 1, 0, MAXP, 1, 1, 0);
    run_op("glitch", W'(100), W'(23), 0, 0, W'(123), 0, 0, 1);

    // start held high: back-to-back accepts
    @(negedge clk); #1;
    opa = W'(128'h1234_5678_9ABC); opb = W'(128'h1111_1111_1111); sub = 0; cin = 0; start = 1;
    k = 0; n = 0;
    while (n < 40 && k < 3) begin
      @(negedge clk);
      n++;
      if (done) begin dc[k] = cyc; k++; end
    end
    #1 start = 0;
    if (k < 3) chk("b2b_timeout", W'(k), W'(3));
    else begin
      chk("b2b_space0", W'(dc[1] - dc[0]), W'(NW + 2));
      chk("b2b_space1", W'(dc[2] - dc[1]), W'(NW + 2));
      chk("b2b_res", result, W'(128'h1234_5678_9ABC) + W'(128'h1111_1111_1111));
    end
    repeat (3) @(negedge clk);

    // reset mid-RUN
    #1 opa = ONES; opb = ONES; sub = 0; cin = 1; start = 1;
    @(negedge clk); #1 start = 0;
    @(negedge clk); #1 rst_n = 0;
    #1;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_result", result, '0);
    chk("abort_cout", W'(cout), W'(0));
    chk("abort_ovf", W'(ovf), W'(0));
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("abort_no_done", W'(cnt), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
